main_memory: RTL
================

# main_memory

Shared vector main memory: the responder for the load/write request ports driven by the processing blocks. It arbitrates round-robin among `PORTS` requesters and performs at most one full-width access per cycle. Loads return their data on a fixed-latency pipeline; writes are committed in the cycle they are granted. It sits between the processing-block array and the backing storage array.

## Interface
- `PORTS`, 2: number of requesting processing blocks.
- `CORES`, 32: lanes per word.
- `BITS`, 16: bits per lane; word width `WW = CORES*BITS`.
- `DEPTH`, 1024: words stored; valid addresses are 0..DEPTH-1.
- `READ_LATENCY`, 2: cycles from load grant to `load_valid`; legal range ≥1.
- Ports:
  - `clock  in  1`: single clock, rising edge.
  - `reset  in  1`: synchronous, active-high.
  - `load_ctrl  in  PORTS`: per-port load request, held high until granted.
  - `load_addr  in  PORTS*16`: per-port load address; port p uses slice [p*16 +: 16].
  - `write_ctrl  in  PORTS`: per-port write request, held high until granted.
  - `write_addr_main  in  PORTS*16`: per-port write address.
  - `write_data_main  in  PORTS*WW`: per-port write data.
  - `grant  out  PORTS`: one-hot or zero; the request is consumed at this clock edge.
  - `load_data  out  PORTS*WW`: per-port returned load word.
  - `load_valid  out  PORTS`: one-cycle pulse qualifying `load_data` for that port.
  - `read_count  out  32`: statistics counter; see Configuration.
  - `write_count  out  32`: statistics counter; see Configuration.
  - `conflict_count  out  32`: statistics counter; see Configuration.

## Operation
- Port p is requesting when `load_ctrl[p] | write_ctrl[p]`.
- Arbitration:
  - `grant` is combinational from the current requests and the round-robin pointer `rr`.
  - The search starts at `rr+1` (mod PORTS); the first requesting port wins.
  - On a grant, `rr` is set to the winner at the clock edge.
  - `rr` resets to PORTS-1, so port 0 has first priority.
- Request selection: if a granted port has both `write_ctrl` and `load_ctrl` high, the write is consumed. The load stays pending and competes again from the next cycle.
- Write: the word is stored at the grant edge. An address ≥ DEPTH drops the write silently; the grant is still given.
- Load:
  - The word is read at the grant edge and carried, tagged with port id, through a `READ_LATENCY`-stage pipeline.
  - An address ≥ DEPTH returns all zeros.
- Read-after-write: a load granted in a cycle after a write to the same address returns the new data. Write and load are never granted in the same cycle, so there is no same-cycle hazard.
- Response: `load_valid[p]` pulses for exactly one cycle. `load_data[p]` holds the last returned word until the next response to p.
- Requests from different ports may return back-to-back. Each port sees responses in grant order.
- Reset (including mid-operation):
  - `rr` returns to PORTS-1 and in-flight loads are discarded; their valids never fire.
  - Storage contents are NOT cleared.

## Timing
- Reset values: `load_valid`=0, `load_data`=0, all counters=0. `grant`=0 while `reset` is high.
- Grant at edge t → `load_valid` high in the cycle following edge t+READ_LATENCY-1, i.e. the data is sampled at edge t+READ_LATENCY.
- Write grant at edge t → data is visible to any load granted at edge t+1 or later.
- Throughput: one grant per cycle in total. A port requesting alone is granted every cycle.
- With N ports continuously requesting, each port is granted once every N cycles.

## Configuration
- Macro: `MAIN_MEMORY_STATS_EN`.
- Defined:
  - `read_count` increments on each load grant.
  - `write_count` increments on each write grant, including dropped out-of-range writes.
  - `conflict_count` increments on each cycle where ≥2 ports request.
  - All three are 32-bit, saturate at 0xFFFFFFFF, and clear on reset.
- Undefined: the counter logic is absent and all three outputs are tied to 0.

## Test plan
- Reset, then port 0 writes 0xABCD to all lanes at addr 5. Next cycle port 0 loads addr 5 → `grant[0]` is immediate, and `load_valid[0]` fires READ_LATENCY=2 cycles later with all lanes 0xABCD.
- Ports 0 and 1 both hold loads for 6 cycles → grants alternate 0,1,0,1,0,1. With STATS enabled, `conflict_count`=6 and `read_count`=6.
- Port 1 asserts write and load together, both to addr 7 → write is granted first, load on the next grant, and the load returns the written data.
- Load addr 1024 (DEPTH=1024) → `load_valid` pulses with data 0. A write to addr 2000 is granted, and memory is unchanged at all addresses.
- Load is granted, then `reset` is asserted the next cycle → no `load_valid` ever fires for it. A word written before reset is still readable after reset.
- Saturation, with the counter preloaded via a force to 0xFFFFFFFE: 3 further writes leave `write_count` at 0xFFFFFFFF.

Source files
------------

// File: rtl/main_memory.sv
// Shared vector memory with a round-robin arbiter across PORTS requesters and a fixed-latency load return path.
// Optional statistics counters are built only when MAIN_MEMORY_STATS_EN is defined.
module main_memory #(
    parameter int PORTS        = 2,
    parameter int CORES        = 32,
    parameter int BITS         = 16,
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [PORTS-1:0]              load_ctrl,
    input  logic [PORTS*16-1:0]           load_addr,
    input  logic [PORTS-1:0]              write_ctrl,
    input  logic [PORTS*16-1:0]           write_addr_main,
    input  logic [PORTS*CORES*BITS-1:0]   write_data_main,
    output logic [PORTS-1:0]              grant,
    output logic [PORTS*CORES*BITS-1:0]   load_data,
    output logic [PORTS-1:0]              load_valid,
    output logic [31:0]                   read_count,
    output logic [31:0]                   write_count,
    output logic [31:0]                   conflict_count
);
    localparam int WW = CORES * BITS;
    localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PORTS-1:0] req;
    logic [PW-1:0]    rr_q, rr_d, win;
    logic             gnt_any, gnt_wr, gnt_ld;
    logic [15:0]      sel_addr;
    logic             addr_ok;
    logic [WW-1:0]    rd_word;
    int unsigned      idx;
    logic [WW-1:0]    mem_q [DEPTH];

    assign req = load_ctrl | write_ctrl;

    // Search starts one past the last winner; nothing is granted while reset is high.
    always_comb begin
        grant   = '0;
        win     = rr_q;
        gnt_any = 1'b0;
        idx     = 0;
        for (int i = 1; i <= PORTS; i++) begin
            idx = (int'(rr_q) + i) % PORTS;
            if (!gnt_any && !reset && req[idx]) begin
                grant[idx] = 1'b1;
                win        = PW'(idx);
                gnt_any    = 1'b1;
            end
        end
    end

    // A port asking for both write and load gets the write; its load waits.
    assign gnt_wr   = gnt_any & write_ctrl[win];
    assign gnt_ld   = gnt_any & ~write_ctrl[win];
    assign sel_addr = gnt_wr ? write_addr_main[int'(win)*16 +: 16] : load_addr[int'(win)*16 +: 16];
    assign addr_ok  = {16'd0, sel_addr} < 32'(DEPTH);
    assign rd_word  = addr_ok ? mem_q[sel_addr[AW-1:0]] : '0;
    assign rr_d     = gnt_any ? win : rr_q;

    always_ff @(posedge clock) begin
        if (reset) rr_q <= PW'(PORTS - 1);
        else       rr_q <= rr_d;
    end

    // Storage survives reset.
    always_ff @(posedge clock) begin
        if (gnt_wr && addr_ok) mem_q[sel_addr[AW-1:0]] <= write_data_main[int'(win)*WW +: WW];
    end

    logic          tail_vld;
    logic [PW-1:0] tail_port;
    logic [WW-1:0] tail_data;

    generate
        if (READ_LATENCY == 1) begin : g_direct
            assign tail_vld  = gnt_ld;
            assign tail_port = win;
            assign tail_data = rd_word;
        end else begin : g_pipe
            logic [READ_LATENCY-2:0] vld_q;
            logic [PW-1:0]           port_q [READ_LATENCY-1];
            logic [WW-1:0]           data_q [READ_LATENCY-1];
            always_ff @(posedge clock) begin
                if (reset) begin
                    vld_q <= '0;
                end else begin
                    vld_q[0] <= gnt_ld;
                    for (int s = 1; s < READ_LATENCY - 1; s++) vld_q[s] <= vld_q[s-1];
                end
                port_q[0] <= win;
                data_q[0] <= rd_word;
                for (int s = 1; s < READ_LATENCY - 1; s++) begin
                    port_q[s] <= port_q[s-1];
                    data_q[s] <= data_q[s-1];
                end
            end
            assign tail_vld  = vld_q[READ_LATENCY-2];
            assign tail_port = port_q[READ_LATENCY-2];
            assign tail_data = data_q[READ_LATENCY-2];
        end
    endgenerate

    logic          out_vld_q;
    logic [PW-1:0] out_port_q;
    logic [WW-1:0] load_data_q [PORTS];

    always_ff @(posedge clock) begin
        if (reset) begin
            out_vld_q  <= 1'b0;
            out_port_q <= '0;
            for (int p = 0; p < PORTS; p++) load_data_q[p] <= '0;
        end else begin
            out_vld_q  <= tail_vld;
            out_port_q <= tail_port;
            for (int p = 0; p < PORTS; p++)
                if (tail_vld && tail_port == PW'(p)) load_data_q[p] <= tail_data;
        end
    end

    always_comb begin
        load_valid = '0;
        load_data  = '0;
        for (int p = 0; p < PORTS; p++) begin
            load_valid[p]          = out_vld_q && (out_port_q == PW'(p));
            load_data[p*WW +: WW]  = load_data_q[p];
        end
    end

`ifdef MAIN_MEMORY_STATS_EN
    logic [31:0] read_count_q, write_count_q, conflict_count_q;

    // Saturating counters: they stop at all-ones rather than wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            read_count_q     <= '0;
            write_count_q    <= '0;
            conflict_count_q <= '0;
        end else begin
            if (gnt_ld && read_count_q != '1)  read_count_q  <= read_count_q + 32'd1;
            if (gnt_wr && write_count_q != '1) write_count_q <= write_count_q + 32'd1;
            if (($countones(req) >= 2) && conflict_count_q != '1)
                conflict_count_q <= conflict_count_q + 32'd1;
        end
    end

    assign read_count     = read_count_q;
    assign write_count    = write_count_q;
    assign conflict_count = conflict_count_q;
`else
    assign read_count     = 32'd0;
    assign write_count    = 32'd0;
    assign conflict_count = 32'd0;
`endif

endmodule
